// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types for the pipeline hazard/sequencing control slice.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SQUASH   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic we;
    logic flush;
  } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use comparator between ID sources and ID/EX dest.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_wn,
  output logic       ldu
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (idex_wn == id_rs);
  assign w_rt_hit = id_uses_rt & (idex_wn == id_rt);
  // $0 is hardwired, so a load targeting it never produces a real dependency
  assign ldu      = idex_mem_read & (idex_wn != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : PC / stage-register enable and flush sequencer for the 5-stage pipe.
//          Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_wn,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_jump,
  input  logic             exmem_mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic             pc_sel_tgt,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int               WAIT_W        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_wait_max   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0]       c_sq_load     = 3'(FLUSH_CYCLES - 1);
  localparam bit               c_use_squash  = (FLUSH_CYCLES > 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
      $error("pipe_hazard_ctrl: FLUSH_CYCLES must be 1..7");
    end
    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
      $error("pipe_hazard_ctrl: MEM_TIMEOUT must be 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_hazard_ctrl: CNT_W must be positive");
    end
  endgenerate

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [2:0]        r_sq_cnt;
  logic [2:0]        w_sq_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_mem_err;

  logic        w_ldu;
  logic        w_redirect;
  logic        w_mwait;
  logic        w_in_squash;
  logic        w_do_redirect;
  logic        w_do_ldu;
  logic        w_squash_hold;
  logic        w_pc_we;
  logic        w_memwb_we;
  stage_ctrl_t w_ifid;
  stage_ctrl_t w_idex;
  stage_ctrl_t w_exmem;

  hazard_detect u_hazard_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_wn       (idex_wn),
    .ldu           (w_ldu)
  );

  assign w_redirect  = exmem_jump | (exmem_branch & exmem_zero);
  assign w_mwait     = exmem_mem_req & ~mem_ready;
  assign w_in_squash = (r_state == SQUASH);

  // mwait beats redirect beats ldu; while squashing, ID holds a flushed NOP
  assign w_do_redirect = ~w_mwait & w_redirect;
  assign w_do_ldu      = ~w_mwait & ~w_redirect & ~w_in_squash & w_ldu;
  assign w_squash_hold = ~w_mwait & ~w_redirect & w_in_squash;

  always_comb begin
    w_pc_we       = ~w_mwait & ~w_do_ldu;
    w_ifid.we     = ~w_mwait & ~w_do_ldu;
    w_ifid.flush  = w_do_redirect | w_squash_hold;
    w_idex.we     = ~w_mwait;
    w_idex.flush  = w_do_redirect | w_do_ldu;
    w_exmem.we    = ~w_mwait;
    w_exmem.flush = w_do_redirect;
    w_memwb_we    = ~w_mwait;

    w_state_nxt = RUN;
    w_sq_nxt    = '0;
    w_wait_nxt  = '0;
    if (w_mwait) begin
      w_state_nxt = MEM_WAIT;
      if (r_state == MEM_WAIT) begin
        w_wait_nxt = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
      end else begin
        w_wait_nxt = WAIT_W'(1);
      end
    end else if (w_redirect && c_use_squash) begin
      w_state_nxt = SQUASH;
      w_sq_nxt    = c_sq_load;
    end else if (w_in_squash) begin
      w_sq_nxt    = r_sq_cnt - 3'd1;
      w_state_nxt = (r_sq_cnt > 3'd1) ? SQUASH : RUN;
    end
  end

  // Reset forces the safe control pattern combinationally, without waiting for a clock
  assign pc_we       = rst_n & w_pc_we;
  assign ifid_we     = rst_n & w_ifid.we;
  assign ifid_flush  = ~rst_n | w_ifid.flush;
  assign idex_we     = rst_n & w_idex.we;
  assign idex_flush  = ~rst_n | w_idex.flush;
  assign exmem_we    = rst_n & w_exmem.we;
  assign exmem_flush = ~rst_n | w_exmem.flush;
  assign memwb_we    = rst_n & w_memwb_we;
  assign pc_sel_tgt  = rst_n & w_do_redirect;
  assign mem_err     = r_mem_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_sq_cnt   <= '0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sq_cnt   <= w_sq_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_mwait && (w_wait_nxt == c_wait_max)) begin
        r_mem_err <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_ev_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_wait_ev_cnt <= '0;
    end else begin
      if (w_do_ldu)      r_stall_cnt   <= r_stall_cnt + CNT_W'(1);
      if (w_do_redirect) r_flush_cnt   <= r_flush_cnt + CNT_W'(1);
      if (w_mwait)       r_wait_ev_cnt <= r_wait_ev_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign wait_cnt  = r_wait_ev_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed + random stimulus against a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int FC  = 3;
  localparam int TMO = 16;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, idex_wn;
  logic       id_uses_rt, idex_mem_read;
  logic       exmem_branch, exmem_zero, exmem_jump, exmem_mem_req, mem_ready;
  logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic       exmem_we, exmem_flush, memwb_we, pc_sel_tgt, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  logic [8:0] ctrl_obs;
  assign ctrl_obs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
                     exmem_we, exmem_flush, memwb_we, pc_sel_tgt};

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_wn       (idex_wn),
    .exmem_branch  (exmem_branch),
    .exmem_zero    (exmem_zero),
    .exmem_jump    (exmem_jump),
    .exmem_mem_req (exmem_mem_req),
    .mem_ready     (mem_ready),
    .pc_we         (pc_we),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .idex_we       (idex_we),
    .idex_flush    (idex_flush),
    .exmem_we      (exmem_we),
    .exmem_flush   (exmem_flush),
    .memwb_we      (memwb_we),
    .pc_sel_tgt    (pc_sel_tgt),
    .mem_err       (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .wait_cnt      (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: consecutive not-ready cycles, remaining squash cycles, sticky error
  int m_wait   = 0;
  int m_squash = 0;
  bit m_err    = 1'b0;
  int m_scnt   = 0;
  int m_fcnt   = 0;
  int m_wcnt   = 0;

  // Expected control words {pc_we,ifid_we,ifid_flush,idex_we,idex_flush,exmem_we,exmem_flush,memwb_we,pc_sel}
  localparam logic [8:0] E_RESET  = 9'b0_0_1_0_1_0_1_0_0;
  localparam logic [8:0] E_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] E_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_REDIR  = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] E_SQUASH = 9'b1_1_1_1_0_1_0_1_0;
  localparam logic [8:0] E_STALL  = 9'b0_0_0_1_1_1_0_1_0;

  task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] wn, input logic br,
                      input logic z, input logic j, input logic req, input logic rdy,
                      input string tag);
    bit redir, ldu, mw;
    logic [8:0] exp;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; idex_mem_read = mr; idex_wn = wn;
    exmem_branch = br; exmem_zero = z; exmem_jump = j; exmem_mem_req = req; mem_ready = rdy;
    redir = j || (br && z);
    ldu   = mr && (wn != 5'd0) && ((wn == rs) || (urt && (wn == rt)));
    mw    = req && !rdy;
    if (mw)               exp = E_FREEZE;
    else if (redir)       exp = E_REDIR;
    else if (m_squash > 0) exp = E_SQUASH;
    else if (ldu)         exp = E_STALL;
    else                  exp = E_NORMAL;
    @(negedge clk);
    check9({tag, "_ctrl"}, ctrl_obs, exp);
    check1({tag, "_err"}, mem_err, m_err);
    if (mw) begin
      m_wait++;
      m_wcnt++;
      m_squash = 0;
      if (m_wait >= TMO) m_err = 1'b1;
    end else begin
      m_wait = 0;
      if (redir) begin
        m_squash = FC - 1;
        m_fcnt++;
      end else if (m_squash > 0) begin
        m_squash--;
      end else if (ldu) begin
        m_scnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  // Asserted shortly after an edge so the check sees the asynchronous response
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check9({tag, "_ctrl"}, ctrl_obs, E_RESET);
    check1({tag, "_err"}, mem_err, 1'b0);
    m_wait = 0; m_squash = 0; m_err = 1'b0;
    m_scnt = 0; m_fcnt = 0; m_wcnt = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; idex_mem_read = 1'b0; idex_wn = '0;
    exmem_branch = 1'b0; exmem_zero = 1'b0; exmem_jump = 1'b0;
    exmem_mem_req = 1'b0; mem_ready = 1'b1;
    #2;
    check9("por_ctrl", ctrl_obs, E_RESET);
    check1("por_err", mem_err, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle("idle");
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ldu_rs");
    idle("ldu_clear");
    step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ldu_r0");
    step(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ldu_rt");
    step(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ldu_rt_unused");

    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "br_taken");
    idle("br_sq1");
    idle("br_sq2");
    idle("br_run");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "br_not_taken");
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "jmp_with_ldu");
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sq_ignores_ldu");
    idle("jmp_sq2");

    for (int i = 0; i < 4; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "mwait");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mwait_ready");
    idle("mwait_after");

    for (int i = 0; i < 2; i++)
      step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "prio_freeze");
    step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "prio_release");
    idle("prio_sq1");
    idle("prio_sq2");
    idle("prio_run");

    for (int i = 0; i < 20; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "timeout");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "timeout_ready");
    idle("timeout_after");
    check1("err_sticky", mem_err, 1'b1);
    apply_reset("err_reset");
    idle("post_reset");

    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "sq_rst_jump");
    idle("sq_rst_sq1");
    apply_reset("mid_squash_reset");
    idle("after_squash_reset");

    for (int i = 0; i < 1500; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), "rand");
    end

`ifdef HAZARD_PERF_CNT_EN
    check9("stall_cnt_lo", stall_cnt[8:0], 9'(m_scnt));
    check9("flush_cnt_lo", flush_cnt[8:0], 9'(m_fcnt));
    check9("wait_cnt_lo", wait_cnt[8:0], 9'(m_wcnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates write-enable and flush controls for PC and each stage register from three events:
  - load-use hazards,
  - taken branch/jump redirects resolved in MEM,
  - data-memory wait states.
- Owns a small FSM for multi-cycle memory waits and redirect squash windows.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID flush stays asserted after a redirect (range 1..7); covers fetch refill latency.
- MEM_TIMEOUT, 16: consecutive not-ready cycles before mem_err is raised (range 2..255).
- CNT_W, 32: width of performance counters (used only under the optional feature).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- idex_mem_read  in  1  MemRead held in ID/EX
- idex_wn  in  5  destination register held in ID/EX
- exmem_branch  in  1  Branch held in EX/MEM
- exmem_zero  in  1  zero flag held in EX/MEM
- exmem_jump  in  1  jump held in EX/MEM
- exmem_mem_req  in  1  EX/MEM MemRead or MemWrite
- mem_ready  in  1  data memory access completes this cycle
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  load bubble (all control 0) into ID/EX
- exmem_we  out  1  EX/MEM write enable
- exmem_flush  out  1  load bubble into EX/MEM
- memwb_we  out  1  MEM/WB write enable
- pc_sel_tgt  out  1  PC takes branch/jump target
- mem_err  out  1  sticky memory timeout flag

Behaviour:
- Clocking and reset:
  - Single clk domain; all state on posedge clk; async clear on rst_n low.
  - During reset: pc_we, ifid_we, idex_we, exmem_we, memwb_we = 0; all flushes = 1; pc_sel_tgt = 0; mem_err = 0; FSM = RUN; counters = 0.
- Controls are combinational from state plus inputs; zero added latency.
- Decoded events:
  - redirect = exmem_jump | (exmem_branch & exmem_zero).
  - ldu = idex_mem_read & (idex_wn != 0) & ((idex_wn == id_rs) | (id_uses_rt & idex_wn == id_rt)).
  - mwait = exmem_mem_req & ~mem_ready.
- Priority: mwait > redirect > ldu.
- FSM state RUN:
  - Default: all we = 1, all flush = 0.
  - mwait: all we = 0, all flush = 0 (full freeze); go to MEM_WAIT; wait counter = 1.
  - Else redirect: pc_sel_tgt = 1, pc_we = 1, ifid_flush = 1, idex_flush = 1, exmem_flush = 1.
    - If FLUSH_CYCLES > 1: go to SQUASH with squash counter = FLUSH_CYCLES-1.
  - Else ldu: pc_we = 0, ifid_we = 0, idex_flush = 1. Exactly one bubble; the hazard clears naturally next cycle.
- FSM state MEM_WAIT:
  - Full freeze while mwait; wait counter increments, saturating at MEM_TIMEOUT.
  - When counter reaches MEM_TIMEOUT, mem_err sets. It is sticky, cleared only by reset; the freeze continues.
  - On mem_ready = 1: controls evaluated as in RUN (redirect/ldu apply in that same cycle); return to RUN; counter cleared.
- FSM state SQUASH:
  - pc_we = 1, ifid_flush = 1, all other we = 1, pc_sel_tgt = 0; counter decrements; at 0 return to RUN.
  - mwait in SQUASH: freeze and go to MEM_WAIT; the remaining squash count is discarded.
  - A new redirect in SQUASH reloads the counter and asserts pc_sel_tgt.
- Boundary cases:
  - Register $0 never causes ldu.
  - Simultaneous redirect and ldu: redirect only; the ldu instruction is flushed anyway.
  - Reset mid-wait or mid-squash: immediate return to reset values.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, flush_cnt, wait_cnt, each CNT_W bits, wrapping on overflow, cleared by reset:
  - stall_cnt increments each ldu bubble cycle;
  - flush_cnt increments per redirect event;
  - wait_cnt increments per freeze cycle.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum (RUN, MEM_WAIT, SQUASH), 2 bits;
  - REG_ZERO constant (5'd0);
  - a stage-control struct {we, flush}.
- One sub-module, hazard_detect: purely combinational ldu comparator, reusable by a future forwarding unit.
- FSM and counters stay in the top.

Test Plan:
- Load-use: idex_mem_read = 1, idex_wn = 8, id_rs = 8 -> pc_we = 0, ifid_we = 0, idex_flush = 1 for exactly 1 cycle; with idex_wn = 0 -> no stall.
- Branch taken: exmem_branch = 1, exmem_zero = 1, FLUSH_CYCLES = 3 -> pc_sel_tgt = 1 for 1 cycle, then ifid_flush = 1 for 2 further cycles, then RUN.
- Memory wait: exmem_mem_req = 1, mem_ready low 4 cycles -> all we = 0 for 4 cycles, all we = 1 on the ready cycle, mem_err = 0.
- Timeout: mem_ready held low 20 cycles with MEM_TIMEOUT = 16 -> mem_err rises after 16 wait cycles and stays 1 after ready returns, until rst_n pulse.
- Priority: mwait, redirect and ldu together -> freeze only; after ready -> redirect flush, no ldu stall.
- Reset mid-SQUASH: rst_n low asynchronously -> all we = 0 and flushes = 1 immediately; after release, FSM in RUN with all we = 1.
